// File: rtl/tx_fifo_feeder.sv
// Buffered byte source for the RS-232 transmitter: DEPTH-entry FIFO plus a tx_en/busy handshake.
// Define TX_FIFO_STATUS_EN to add the fill_level and sticky overflow status outputs.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | no frame in flight; pops the next word when FIFO not empty
//  LOAD      | tx_en high for this single cycle, transmit_data valid
//  WAIT_BUSY | waiting for the transmitter to raise busy
//  WAIT_DONE | frame on the line; waiting for busy to fall
module tx_fifo_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    input  logic                  tx_busy,
    output logic                  tx_en,
`ifdef TX_FIFO_STATUS_EN
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
`endif
    output logic [DATA_WIDTH-1:0] transmit_data
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]    count, count_nxt;
    logic                    push, pop;

    // Push decision uses the registered full flag, so a pop in the same cycle never rescues it.
    assign push = wr_en && !full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            tx_en         <= 1'b0;
            transmit_data <= '1;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_COUNT);
            tx_en <= (state_nxt == LOAD);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                transmit_data <= mem[rd_ptr];
            end
        end
    end

`ifdef TX_FIFO_STATUS_EN
    assign fill_level = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
    end
`endif

endmodule
